// File: rtl/conv_bias_seq.sv
// conv_bias_seq
// Bias stage between the convolution accumulator and the quantiser.
// Accumulator beats (PIX_PAR x CH_PAR signed lanes) are buffered in a
// first-word-fall-through FIFO. Each beat leaving the FIFO gets the bias of
// its channel group added through one registered adder stage. The block
// tracks the group and pixel position of every beat by itself, so the
// upstream only has to deliver beats in order: group 0 pixels 0..P-1, then
// group 1, and so on.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   Next_Reg                 synchronous layer restart (drops all in-flight beats)
//   Channel_Out_Num_REG      total output channels; groups G = channels / CH_PAR
//   Pix_Per_Group_REG        beats per channel group P
//   bias_wr_en/addr/data     write port of the per-group bias table
//   S_Data/S_Valid/S_Ready   input stream (S_Ready = FIFO not full)
//   M_Data/M_Valid/M_Ready   biased output stream with back-pressure
//   M_Group, M_Last          group of the current beat, last beat of the layer
//   done                     one-cycle pulse after the last beat is accepted
//   overflow                 sticky lane-overflow flag, cleared by Next_Reg
//
// Build option
//   BIAS_SATURATE_EN         when defined, overflowing lanes clamp to the
//                            signed range instead of wrapping around.

module conv_bias_seq #(
  parameter int PIX_PAR   = 2,
  parameter int CH_PAR    = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int GRP_W     = 7,
  parameter int CH_REG_W  = 10,
  parameter int PIX_CNT_W = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               Next_Reg,
  input  logic [CH_REG_W-1:0]                Channel_Out_Num_REG,
  input  logic [PIX_CNT_W-1:0]               Pix_Per_Group_REG,
  input  logic                               bias_wr_en,
  input  logic [GRP_W-1:0]                   bias_wr_addr,
  input  logic [CH_PAR*DATA_W-1:0]           bias_wr_data,
  input  logic [PIX_PAR*CH_PAR*DATA_W-1:0]   S_Data,
  input  logic                               S_Valid,
  output logic                               S_Ready,
  output logic [PIX_PAR*CH_PAR*DATA_W-1:0]   M_Data,
  output logic                               M_Valid,
  input  logic                               M_Ready,
  output logic [GRP_W-1:0]                   M_Group,
  output logic                               M_Last,
  output logic                               done,
  output logic                               overflow
);

  localparam int LANES    = PIX_PAR * CH_PAR;
  localparam int LANE_W   = LANES * DATA_W;
  localparam int BIAS_W   = CH_PAR * DATA_W;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int GROUPS   = 1 << GRP_W;
  localparam int CH_SHIFT = $clog2(CH_PAR);

  logic [LANE_W-1:0]     r_fifoMem [DEPTH];
  logic [BIAS_W-1:0]     r_biasMem [GROUPS];
  logic [ADDR_W-1:0]     r_wrPtr;
  logic [ADDR_W-1:0]     r_rdPtr;
  logic [ADDR_W:0]       r_count;
  logic [GRP_W-1:0]      r_grp;
  logic [GRP_W-1:0]      r_grpLast;
  logic [PIX_CNT_W-1:0]  r_pix;
  logic [PIX_CNT_W-1:0]  r_pixLast;
  logic                  r_mValid;
  logic [LANE_W-1:0]     r_mData;
  logic [GRP_W-1:0]      r_mGroup;
  logic                  r_mLast;
  logic                  r_done;
  logic                  r_ovf;

  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_idle;
  logic [CH_REG_W-1:0]   w_grpCnt;
  logic [GRP_W-1:0]      w_grpLastCfg;
  logic [PIX_CNT_W-1:0]  w_pixLastCfg;
  logic [LANE_W-1:0]     w_head;
  logic [BIAS_W-1:0]     w_bias;
  logic [LANE_W-1:0]     w_sum;
  logic [LANES-1:0]      w_laneOvf;
  logic                  w_unusedCfgBits;

  // Handshake qualifiers. A beat may leave the FIFO whenever the output
  // register is empty or is being accepted in this same cycle.
  assign w_empty = (r_count == '0);
  assign S_Ready = (r_count < (ADDR_W+1)'(DEPTH));
  assign w_push  = S_Valid && S_Ready;
  assign w_pop   = !w_empty && (!r_mValid || M_Ready);
  assign w_idle  = w_empty && !r_mValid;

  // Config is turned into "last index" form; a zero count behaves as one.
  assign w_grpCnt        = Channel_Out_Num_REG >> CH_SHIFT;
  assign w_grpLastCfg    = (w_grpCnt == '0) ? '0 : GRP_W'(w_grpCnt - CH_REG_W'(1));
  assign w_pixLastCfg    = (Pix_Per_Group_REG == '0) ? '0
                         : Pix_Per_Group_REG - PIX_CNT_W'(1);
  assign w_unusedCfgBits = ^Channel_Out_Num_REG[CH_SHIFT-1:0];

  // Head of the FIFO and bias row of the current group are read
  // combinationally, so a bias write in the pop cycle still sees the old row.
  assign w_head = r_fifoMem[r_rdPtr];
  assign w_bias = r_biasMem[r_grp];

  // One signed adder per lane; lane l belongs to channel l / PIX_PAR.
  // Overflow: operands share a sign that the sum does not.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int C = l / PIX_PAR;
    logic signed [DATA_W-1:0] w_a;
    logic signed [DATA_W-1:0] w_b;
    logic signed [DATA_W-1:0] w_s;
    logic                     w_ovf;
    assign w_a   = w_head[l*DATA_W +: DATA_W];
    assign w_b   = w_bias[C*DATA_W +: DATA_W];
    assign w_s   = w_a + w_b;
    assign w_ovf = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_s[DATA_W-1] != w_a[DATA_W-1]);
    assign w_laneOvf[l] = w_ovf;
`ifdef BIAS_SATURATE_EN
    assign w_sum[l*DATA_W +: DATA_W] = !w_ovf ? w_s
                                     : (w_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                      : {1'b0, {(DATA_W-1){1'b1}}});
`else
    assign w_sum[l*DATA_W +: DATA_W] = w_s;
`endif
  end

  // Storage arrays carry no reset: the FIFO is emptied by its pointers and
  // the bias table must survive both reset and layer restarts.
  always_ff @(posedge clk) begin
    if (w_push && !Next_Reg) begin
      r_fifoMem[r_wrPtr] <= S_Data;
    end
    if (bias_wr_en) begin
      r_biasMem[bias_wr_addr] <= bias_wr_data;
    end
  end

  // Control and output register. Next_Reg wins over any same-cycle push,
  // pop or handshake, so the beat involved is simply lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_grp     <= '0;
      r_grpLast <= '0;
      r_pix     <= '0;
      r_pixLast <= '0;
      r_mValid  <= 1'b0;
      r_mData   <= '0;
      r_mGroup  <= '0;
      r_mLast   <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (Next_Reg) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_grp    <= '0;
      r_pix    <= '0;
      r_mValid <= 1'b0;
      r_mLast  <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_idle) begin
        r_grpLast <= w_grpLastCfg;
        r_pixLast <= w_pixLastCfg;
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + ADDR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (ADDR_W+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (ADDR_W+1)'(1);
      end
      r_done <= r_mValid && M_Ready && r_mLast;
      if (w_pop) begin
        r_mValid <= 1'b1;
        r_mData  <= w_sum;
        r_mGroup <= r_grp;
        r_mLast  <= (r_grp == r_grpLast) && (r_pix == r_pixLast);
        if (|w_laneOvf) begin
          r_ovf <= 1'b1;
        end
        if (r_pix == r_pixLast) begin
          r_pix <= '0;
          r_grp <= (r_grp == r_grpLast) ? '0 : r_grp + GRP_W'(1);
        end else begin
          r_pix <= r_pix + PIX_CNT_W'(1);
        end
      end else if (r_mValid && M_Ready) begin
        r_mValid <= 1'b0;
      end
    end
  end

  assign M_Data   = r_mData;
  assign M_Valid  = r_mValid;
  assign M_Group  = r_mGroup;
  assign M_Last   = r_mLast;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_conv_bias_seq.sv
`timescale 1ns/1ps
module tb_conv_bias_seq;

  localparam int PIX_PAR   = 2;
  localparam int CH_PAR    = 8;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 2;
  localparam int GRP_W     = 7;
  localparam int CH_REG_W  = 10;
  localparam int PIX_CNT_W = 16;
  localparam int LANES     = PIX_PAR * CH_PAR;
  localparam int LW        = LANES * DATA_W;
  localparam int BW        = CH_PAR * DATA_W;

  logic                 clk;
  logic                 rst;
  logic                 Next_Reg;
  logic [CH_REG_W-1:0]  Channel_Out_Num_REG;
  logic [PIX_CNT_W-1:0] Pix_Per_Group_REG;
  logic                 bias_wr_en;
  logic [GRP_W-1:0]     bias_wr_addr;
  logic [BW-1:0]        bias_wr_data;
  logic [LW-1:0]        S_Data;
  logic                 S_Valid;
  logic                 S_Ready;
  logic [LW-1:0]        M_Data;
  logic                 M_Valid;
  logic                 M_Ready;
  logic [GRP_W-1:0]     M_Group;
  logic                 M_Last;
  logic                 done;
  logic                 overflow;

  conv_bias_seq #(
    .PIX_PAR(PIX_PAR), .CH_PAR(CH_PAR), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .GRP_W(GRP_W), .CH_REG_W(CH_REG_W), .PIX_CNT_W(PIX_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .Next_Reg(Next_Reg),
    .Channel_Out_Num_REG(Channel_Out_Num_REG), .Pix_Per_Group_REG(Pix_Per_Group_REG),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
    .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
    .M_Group(M_Group), .M_Last(M_Last), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0]    d;
    logic [GRP_W-1:0] g;
    logic             l;
  } beat_t;

  beat_t         expQ[$];
  beat_t         gotQ[$];
  beat_t         mE;
  logic [BW-1:0] mBias [128];
  int            mPix = 0;
  int            mGrp = 0;
  int            mG;
  int            mP;
  logic          doneExp = 1'b0;
  logic          doneNext;
  logic          stallPrev = 1'b0;
  logic [LW-1:0] dataPrev;
  int            doneSeen = 0;
  int            checks = 0;
  int            errors = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference arithmetic: each lane plus the bias of its channel, computed in
  // 64-bit integers and then wrapped or clamped to the 32-bit signed range.
  function automatic logic [LW-1:0] modelSum(input logic [LW-1:0] din, input int g);
    logic [LW-1:0] r;
    logic [BW-1:0] row;
    longint a;
    longint b;
    longint s;
    r   = '0;
    row = mBias[g];
    for (int l = 0; l < LANES; l++) begin
      a = longint'($signed(din[l*DATA_W +: DATA_W]));
      b = longint'($signed(row[(l/PIX_PAR)*DATA_W +: DATA_W]));
      s = a + b;
`ifdef BIAS_SATURATE_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      r[l*DATA_W +: DATA_W] = s[31:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] gotLane(input int i, input int l);
    logic [LW-1:0] t;
    if (i >= gotQ.size()) return 32'hDEADBEEF;
    t = gotQ[i].d;
    return t[l*DATA_W +: DATA_W];
  endfunction

  // Scoreboard: every input beat is turned into its expected output beat,
  // every output handshake is compared against the oldest expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      expQ.delete();
      mPix      = 0;
      mGrp      = 0;
      doneExp   = 1'b0;
      stallPrev = 1'b0;
    end else begin
      checkOutput("done", LW'(done), LW'(doneExp));
      if (done) doneSeen++;
      if (stallPrev) begin
        checkOutput("stall valid", LW'(M_Valid), LW'(1));
        checkOutput("stall data", M_Data, dataPrev);
      end
      doneNext = 1'b0;
      if (Next_Reg) begin
        expQ.delete();
        mPix      = 0;
        mGrp      = 0;
        stallPrev = 1'b0;
      end else begin
        if (M_Valid && M_Ready) begin
          gotQ.push_back('{M_Data, M_Group, M_Last});
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected beat: got data %0h, expected no beat", M_Data);
          end else begin
            mE = expQ.pop_front();
            checkOutput("M_Data", M_Data, mE.d);
            checkOutput("M_Group", LW'(M_Group), LW'(mE.g));
            checkOutput("M_Last", LW'(M_Last), LW'(mE.l));
            doneNext = mE.l;
          end
        end
        if (S_Valid && S_Ready) begin
          mG = int'(Channel_Out_Num_REG) / CH_PAR;
          if (mG == 0) mG = 1;
          mP = int'(Pix_Per_Group_REG);
          if (mP == 0) mP = 1;
          mE.d = modelSum(S_Data, mGrp);
          mE.g = GRP_W'(mGrp);
          mE.l = (mGrp == mG - 1) && (mPix == mP - 1);
          expQ.push_back(mE);
          if (mPix == mP - 1) begin
            mPix = 0;
            mGrp = (mGrp == mG - 1) ? 0 : mGrp + 1;
          end else begin
            mPix++;
          end
        end
        stallPrev = M_Valid && !M_Ready;
        dataPrev  = M_Data;
      end
      doneExp = doneNext;
      if (bias_wr_en) mBias[bias_wr_addr] = bias_wr_data;
    end
  end

  // Offer one beat (lane l = v + l*offs) for at most maxWait cycles.
  task automatic applyStimulus(input logic [31:0] v, input int offs, input int maxWait, output bit acc);
    S_Valid = 1'b1;
    for (int l = 0; l < LANES; l++) S_Data[l*DATA_W +: DATA_W] = v + 32'(l * offs);
    acc = 1'b0;
    for (int n = 0; n < maxWait; n++) begin
      @(negedge clk);
      if (S_Ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    S_Valid = 1'b0;
  endtask

  task automatic sendBeat(input logic [31:0] v, input int offs);
    bit acc;
    applyStimulus(v, offs, 100, acc);
    checkOutput("send accepted", LW'(acc), LW'(1));
  endtask

  task automatic setBias(input int g, input logic [31:0] base, input logic [31:0] step);
    bias_wr_en   = 1'b1;
    bias_wr_addr = GRP_W'(g);
    for (int c = 0; c < CH_PAR; c++) bias_wr_data[c*DATA_W +: DATA_W] = base + 32'(c) * step;
    @(posedge clk); #1;
    bias_wr_en = 1'b0;
  endtask

  task automatic nextLayer();
    Next_Reg = 1'b1;
    @(posedge clk); #1;
    Next_Reg = 1'b0;
  endtask

  task automatic waitBeats(input int n);
    for (int i = 0; i < 300; i++) begin
      if (gotQ.size() >= n) break;
      @(negedge clk);
    end
    checkOutput("beat count", LW'(gotQ.size()), LW'(n));
    repeat (3) @(negedge clk);
  endtask

  int acceptedCnt;
  bit acc;
  logic [31:0] ovfExp;

  initial begin
    rst = 1'b0; Next_Reg = 1'b0; bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
    S_Data = '0; S_Valid = 1'b0; M_Ready = 1'b1;
    Channel_Out_Num_REG = 10'd8; Pix_Per_Group_REG = 16'd4;
    #2;
    checkOutput("reset M_Valid", LW'(M_Valid), LW'(0));
    checkOutput("reset M_Data", M_Data, LW'(0));
    checkOutput("reset M_Group", LW'(M_Group), LW'(0));
    checkOutput("reset M_Last", LW'(M_Last), LW'(0));
    checkOutput("reset done", LW'(done), LW'(0));
    checkOutput("reset overflow", LW'(overflow), LW'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    checkOutput("reset S_Ready", LW'(S_Ready), LW'(1));

    // Single group, bias c+1, four beats of 100.
    $display("[TB] bias load and single group");
    setBias(0, 32'd1, 32'd1);
    gotQ.delete();
    doneSeen = 0;
    for (int k = 0; k < 4; k++) sendBeat(32'd100, 0);
    waitBeats(4);
    checkOutput("t1 ch0 lane", LW'(gotLane(0, 0)), LW'(101));
    checkOutput("t1 ch3 lane", LW'(gotLane(0, 7)), LW'(104));
    checkOutput("t1 ch7 lane", LW'(gotLane(2, 15)), LW'(108));
    checkOutput("t1 last beat0", LW'(gotQ[0].l), LW'(0));
    checkOutput("t1 last beat3", LW'(gotQ[3].l), LW'(1));
    checkOutput("t1 done pulses", LW'(doneSeen), LW'(1));

    // Three groups of two beats, bias 1000*g.
    $display("[TB] group sequencing");
    Channel_Out_Num_REG = 10'd24; Pix_Per_Group_REG = 16'd2;
    for (int g = 0; g < 3; g++) setBias(g, 32'(1000 * g), 32'd0);
    gotQ.delete();
    for (int k = 0; k < 6; k++) sendBeat(32'd5, 0);
    waitBeats(6);
    checkOutput("t2 b0", LW'(gotLane(0, 0)), LW'(5));
    checkOutput("t2 b1", LW'(gotLane(1, 0)), LW'(5));
    checkOutput("t2 b2", LW'(gotLane(2, 0)), LW'(1005));
    checkOutput("t2 b3", LW'(gotLane(3, 0)), LW'(1005));
    checkOutput("t2 b4", LW'(gotLane(4, 0)), LW'(2005));
    checkOutput("t2 b5", LW'(gotLane(5, 0)), LW'(2005));
    checkOutput("t2 grp b3", LW'(gotQ[3].g), LW'(1));
    checkOutput("t2 grp b5", LW'(gotQ[5].g), LW'(2));
    sendBeat(32'd5, 0);
    waitBeats(7);
    checkOutput("t2 wrap grp", LW'(gotQ[6].g), LW'(0));
    checkOutput("t2 wrap data", LW'(gotLane(6, 0)), LW'(5));

    // Back-pressure into a four-deep FIFO.
    $display("[TB] back-pressure and full FIFO");
    nextLayer();
    Channel_Out_Num_REG = 10'd8; Pix_Per_Group_REG = 16'd8;
    M_Ready = 1'b0;
    gotQ.delete();
    acceptedCnt = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(32'(k * 10), 1, 6, acc);
      if (!acc) break;
      acceptedCnt++;
    end
    checkOutput("t3 accepted", LW'(acceptedCnt), LW'(5));
    checkOutput("t3 S_Ready low", LW'(S_Ready), LW'(0));
    repeat (3) @(posedge clk);
    #1 M_Ready = 1'b1;
    for (int k = acceptedCnt; k < 8; k++) sendBeat(32'(k * 10), 1);
    waitBeats(8);
    for (int k = 0; k < 8; k++) checkOutput("t3 order", LW'(gotLane(k, 3)), LW'(k * 10 + 3));
    checkOutput("t3 last", LW'(gotQ[7].l), LW'(1));

    // Positive overflow on every lane.
    $display("[TB] overflow");
    nextLayer();
    Pix_Per_Group_REG = 16'd1;
    setBias(0, 32'h20, 32'd0);
    gotQ.delete();
    sendBeat(32'h7FFFFFF0, 0);
    waitBeats(1);
`ifdef BIAS_SATURATE_EN
    ovfExp = 32'h7FFFFFFF;
`else
    ovfExp = 32'h80000010;
`endif
    checkOutput("t4 ovf lane", LW'(gotLane(0, 0)), LW'(ovfExp));
    checkOutput("t4 ovf flag", LW'(overflow), LW'(1));
    sendBeat(32'd1, 0);
    waitBeats(2);
    checkOutput("t4 normal lane", LW'(gotLane(1, 5)), LW'(32'h21));
    checkOutput("t4 ovf sticky", LW'(overflow), LW'(1));
    nextLayer();
    checkOutput("t4 ovf cleared", LW'(overflow), LW'(0));

    // Restart mid-layer with a beat offered in the same cycle.
    $display("[TB] Next_Reg mid-layer");
    Pix_Per_Group_REG = 16'd8;
    setBias(0, 32'd1, 32'd1);
    for (int k = 0; k < 3; k++) sendBeat(32'd200, 0);
    S_Valid = 1'b1;
    for (int l = 0; l < LANES; l++) S_Data[l*DATA_W +: DATA_W] = 32'd999;
    Next_Reg = 1'b1;
    @(posedge clk); #1;
    Next_Reg = 1'b0; S_Valid = 1'b0;
    @(negedge clk);
    checkOutput("t5 M_Valid", LW'(M_Valid), LW'(0));
    checkOutput("t5 S_Ready", LW'(S_Ready), LW'(1));
    gotQ.delete();
    for (int k = 0; k < 8; k++) sendBeat(32'd300, 0);
    waitBeats(8);
    checkOutput("t5 first grp", LW'(gotQ[0].g), LW'(0));
    checkOutput("t5 first lane", LW'(gotLane(0, 0)), LW'(301));
    checkOutput("t5 bias kept", LW'(gotLane(0, 15)), LW'(308));
    checkOutput("t5 last b6", LW'(gotQ[6].l), LW'(0));
    checkOutput("t5 last b7", LW'(gotQ[7].l), LW'(1));

    // Asynchronous reset while beats are moving.
    $display("[TB] async reset mid-stream");
    S_Valid = 1'b1;
    for (int l = 0; l < LANES; l++) S_Data[l*DATA_W +: DATA_W] = 32'd400;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6 pre-reset valid", LW'(M_Valid), LW'(1));
    #2 rst = 1'b0;
    #1;
    checkOutput("t6 M_Valid", LW'(M_Valid), LW'(0));
    checkOutput("t6 M_Data", M_Data, LW'(0));
    checkOutput("t6 M_Group", LW'(M_Group), LW'(0));
    checkOutput("t6 M_Last", LW'(M_Last), LW'(0));
    checkOutput("t6 done", LW'(done), LW'(0));
    S_Valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6 S_Ready", LW'(S_Ready), LW'(1));
    gotQ.delete();
    sendBeat(32'd500, 0);
    waitBeats(1);
    checkOutput("t6 grp", LW'(gotQ[0].g), LW'(0));
    checkOutput("t6 lane", LW'(gotLane(0, 0)), LW'(501));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_bias_seq.md
Name: conv_bias_seq

Overview:
Parametrised successor of the conv output bias stage. It buffers PIX_PAR×CH_PAR accumulator lanes in an internal FIFO and selects the bias per channel group from an on-chip bias table. It tracks group and pixel position itself and adds the bias through one registered adder stage. Output uses a valid/ready handshake with back-pressure, a last-beat marker and a done pulse. It sits between the convolution accumulator and the quantisation stage.

Parameters:
PIX_PAR, 2, pixels processed in parallel per beat
CH_PAR, 8, output channels per beat (power of two)
DATA_W, 32, signed lane width for accumulator, bias and sum
ADDR_W, 10, FIFO address bits; depth = 2^ADDR_W
GRP_W, 7, bias table address bits; max groups = 2^GRP_W
CH_REG_W, 10, width of channel-count config
PIX_CNT_W, 16, width of pixels-per-group config

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
Next_Reg  in  1  synchronous layer restart
Channel_Out_Num_REG  in  CH_REG_W  total output channels of the layer
Pix_Per_Group_REG  in  PIX_CNT_W  beats per channel group
bias_wr_en  in  1  bias table write strobe
bias_wr_addr  in  GRP_W  bias table group index
bias_wr_data  in  CH_PAR*DATA_W  CH_PAR biases; channel c at bits [(c+1)*DATA_W-1:c*DATA_W]
S_Data  in  PIX_PAR*CH_PAR*DATA_W  lane (c*PIX_PAR+p) at bits [(c*PIX_PAR+p+1)*DATA_W-1:(c*PIX_PAR+p)*DATA_W]
S_Valid  in  1  input beat valid
S_Ready  out  1  FIFO not full
M_Data  out  PIX_PAR*CH_PAR*DATA_W  biased lanes, same lane mapping as S_Data
M_Valid  out  1  output beat valid
M_Ready  in  1  downstream accept
M_Group  out  GRP_W  channel group of the current M_Data
M_Last  out  1  current beat is the last beat of the last group
done  out  1  one-cycle pulse, layer complete
overflow  out  1  sticky: some lane sum overflowed

Behaviour:
- Reset (rst=0, async): FIFO empty, all counters 0, M_Valid=0, M_Data=0, M_Group=0, M_Last=0, done=0, overflow=0, S_Ready=1 once rst deasserts. The bias table is not reset.
- Groups: G = Channel_Out_Num_REG >> log2(CH_PAR); G=0 is treated as 1. P = Pix_Per_Group_REG; P=0 is treated as 1. Config is sampled only while the FIFO is empty and no beat is in flight.
- Input ordering: group 0 beats 0..P-1, then group 1, …, up to group G-1.
- FIFO:
  - Write when S_Valid && S_Ready.
  - S_Ready = (count < 2^ADDR_W), registered count.
  - First-word-fall-through head.
  - Simultaneous read and write keeps count unchanged.
- Pop condition: pop = !empty && (!M_Valid || M_Ready).
- On pop:
  - The output register loads head lane + bias_mem[grp][c] for every lane.
  - M_Group <= grp.
  - M_Last <= (grp==G-1 && pix==P-1).
  - pix increments; on reaching P-1 it wraps to 0 and grp increments; grp wraps to 0 after G-1.
- Without a pop: if M_Valid && M_Ready, M_Valid <= 0; otherwise the output register holds stable.
- Latency: a beat written at cycle t appears on M at t+2 at the earliest.
- Throughput: 1 beat/clk with M_Ready held high.
- Bias write:
  - Takes effect at the next edge.
  - A same-cycle write and pop on the same group uses the old value.
  - Writes are allowed at any time.
- Arithmetic: signed DATA_W + DATA_W. Overflow occurs when both operands have the same sign and the sum sign differs; overflow then sets the sticky flag.
- done: registered, high for one cycle after the handshake (M_Valid && M_Ready) of a beat with M_Last=1.
- Next_Reg (synchronous):
  - Empties the FIFO, zeroes pix and grp, clears M_Valid, M_Last, done and overflow.
  - Has priority over a same-cycle write, pop or handshake; that beat is dropped.
  - Leaves the bias table intact.
- Mid-operation asynchronous reset: immediate return to the reset values above; any partial layer is discarded.

Optional Feature:
Macro BIAS_SATURATE_EN.
- Defined: an overflowing lane clamps to 2^(DATA_W-1)-1 (positive overflow) or -2^(DATA_W-1) (negative overflow); the overflow flag is still set.
- Undefined: two's-complement wrap; the overflow flag is still set.

Test Plan:
- Bias load and single group: CH_PAR=8, G=1 (Channel_Out_Num_REG=8), P=4. Load bias[0][c]=c+1. Send lanes = 100. -> M lanes 101..108 by channel, M_Last only on beat 3, done 1 cycle after its handshake, M_Group=0.
- Group sequencing: Channel_Out_Num_REG=24 (G=3), P=2, bias[g][c]=1000*g. Send 6 beats of 5. -> outputs 5,5,1005,1005,2005,2005; M_Group 0,0,1,1,2,2; groups wrap to 0 for the next layer.
- Back-pressure and full FIFO: ADDR_W=2. Hold M_Ready=0 and stream 8 beats. -> S_Ready falls after 4 FIFO writes plus 1 held in the output register. No data is lost or duplicated; order is preserved after release; M_Data stays stable while stalled.
- Overflow: lane 0x7FFFFFF0 + bias 0x20. -> with BIAS_SATURATE_EN: 0x7FFFFFFF; without it: 0x80000010. overflow=1 and sticky until Next_Reg.
- Next_Reg mid-layer: pulse Next_Reg after 3 of 8 beats, concurrent with S_Valid. -> FIFO empty, M_Valid=0, that beat dropped, next layer starts at group 0 pixel 0, bias table unchanged.
- Async reset mid-stream: drop rst during an active handshake. -> all outputs 0 at once without a clock edge; after release S_Ready=1 and the next beat uses group 0.
